// File: rtl/fwd_pipeline_datapath.sv
// -----------------------------------------------------------------------------
// fwd_pipeline_datapath
//
// Five-stage (IF, ID, EX, MM, WB) integer pipeline for a small MIPS-style
// instruction subset: add, sub, and, or, slt (R-type) and addi. There are no
// branches and no data memory, so MM is a pass-through stage.
//
// A result reaches a dependent instruction without bubbles:
//   - EX/MM and MM/WB results are forwarded into the EX operands.
//   - A write committing in WB is bypassed into the ID register read.
//   - Anything older is read from the register file.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides stall)
//   stall      freezes PC, every pipeline register and the register file
//   imem_addr  instruction fetch address (the PC register)
//   imem_data  instruction word at imem_addr, combinational read
//   wb_valid   a register write commits this cycle
//   wb_rd      destination register of the committing write
//   wb_data    value being written
// -----------------------------------------------------------------------------
module fwd_pipeline_datapath #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_data,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef struct packed {
    alu_op_e    op;
    logic       use_imm;
    logic [4:0] dst;
  } dec_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;

  // True for every instruction that produces a register result. Unknown
  // opcodes and funct codes fall through as NOPs.
  function automatic logic writes_reg(input logic [31:0] instr);
    logic w;
    w = 1'b0;
    if (instr[31:26] == OPC_RTYPE) begin
      case (instr[5:0])
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: w = 1'b1;
        default:                           w = 1'b0;
      endcase
    end else if (instr[31:26] == OPC_ADDI) begin
      w = 1'b1;
    end
    return w;
  endfunction

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.op      = ALU_ADD;
    d.use_imm = 1'b0;
    d.dst     = instr[15:11];
    if (instr[31:26] == OPC_ADDI) begin
      d.use_imm = 1'b1;
      d.dst     = instr[20:16];
    end else begin
      case (instr[5:0])
        6'h22:   d.op = ALU_SUB;
        6'h24:   d.op = ALU_AND;
        6'h25:   d.op = ALU_OR;
        6'h2A:   d.op = ALU_SLT;
        default: d.op = ALU_ADD;
      endcase
    end
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0]   r_pc;

  logic              r_fd_valid;
  logic              r_fd_we;
  logic [31:0]       r_fd_instr;

  logic              r_de_valid;
  logic              r_de_we;
  alu_op_e           r_de_op;
  logic              r_de_use_imm;
  logic [4:0]        r_de_rs;
  logic [4:0]        r_de_rt;
  logic [4:0]        r_de_rd;
  logic [DATA_W-1:0] r_de_rs_val;
  logic [DATA_W-1:0] r_de_rt_val;
  logic [DATA_W-1:0] r_de_imm;

  logic              r_em_valid;
  logic              r_em_we;
  logic [4:0]        r_em_rd;
  logic [DATA_W-1:0] r_em_data;

  logic              r_mw_valid;
  logic              r_mw_we;
  logic [4:0]        r_mw_rd;
  logic [DATA_W-1:0] r_mw_data;

  logic [DATA_W-1:0] r_rf [32];

  // ---------------------------------------------------------------------------
  // WB commit: gated by stall so a held instruction commits exactly once,
  // in the first unstalled cycle.
  // ---------------------------------------------------------------------------
  logic w_wb_commit;
  assign w_wb_commit = r_mw_valid & r_mw_we & (r_mw_rd != 5'd0) & ~stall;

  // ---------------------------------------------------------------------------
  // ID: decode, register read with WB bypass, immediate sign extension
  // ---------------------------------------------------------------------------
  dec_t              w_dec;
  logic [4:0]        w_id_rs;
  logic [4:0]        w_id_rt;
  logic [15:0]       w_imm16;
  logic [DATA_W-1:0] w_id_imm;
  logic [DATA_W-1:0] w_id_rs_val;
  logic [DATA_W-1:0] w_id_rt_val;

  assign w_dec   = decode(r_fd_instr);
  assign w_id_rs = r_fd_instr[25:21];
  assign w_id_rt = r_fd_instr[20:16];
  assign w_imm16 = r_fd_instr[15:0];

  // Sign-extend or truncate the 16-bit immediate to DATA_W bits.
  always_comb begin
    w_id_imm = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_id_imm[i] = (i < 16) ? w_imm16[i[3:0]] : w_imm16[15];
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_id_rs_val = r_rf[w_id_rs];
    if (w_id_rs == 5'd0) begin
      w_id_rs_val = '0;
    end else if (w_wb_commit && (r_mw_rd == w_id_rs)) begin
      w_id_rs_val = r_mw_data;
    end

    w_id_rt_val = r_rf[w_id_rt];
    if (w_id_rt == 5'd0) begin
      w_id_rt_val = '0;
    end else if (w_wb_commit && (r_mw_rd == w_id_rt)) begin
      w_id_rt_val = r_mw_data;
    end
  end

  // ---------------------------------------------------------------------------
  // EX: operand forwarding (EX/MM before MM/WB before ID value) and ALU
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_ex_a;
  logic [DATA_W-1:0] w_ex_rt;
  logic [DATA_W-1:0] w_ex_b;
  logic              w_ex_lt;
  logic [DATA_W-1:0] w_ex_result;

  always_comb begin
    w_ex_a = r_de_rs_val;
    if (r_em_valid && r_em_we && (r_em_rd == r_de_rs) && (r_de_rs != 5'd0)) begin
      w_ex_a = r_em_data;
    end else if (r_mw_valid && r_mw_we && (r_mw_rd == r_de_rs) && (r_de_rs != 5'd0)) begin
      w_ex_a = r_mw_data;
    end

    w_ex_rt = r_de_rt_val;
    if (r_em_valid && r_em_we && (r_em_rd == r_de_rt) && (r_de_rt != 5'd0)) begin
      w_ex_rt = r_em_data;
    end else if (r_mw_valid && r_mw_we && (r_mw_rd == r_de_rt) && (r_de_rt != 5'd0)) begin
      w_ex_rt = r_mw_data;
    end
  end

  assign w_ex_b  = r_de_use_imm ? r_de_imm : w_ex_rt;
  assign w_ex_lt = $signed(w_ex_a) < $signed(w_ex_b);

  always_comb begin
    w_ex_result = '0;
    case (r_de_op)
      ALU_ADD: w_ex_result = w_ex_a + w_ex_b;
      ALU_SUB: w_ex_result = w_ex_a - w_ex_b;
      ALU_AND: w_ex_result = w_ex_a & w_ex_b;
      ALU_OR:  w_ex_result = w_ex_a | w_ex_b;
      ALU_SLT: w_ex_result = {{(DATA_W-1){1'b0}}, w_ex_lt};
      default: w_ex_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential: PC, pipeline registers and register file
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, which is what a pipeline needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= '0;
      r_fd_valid   <= 1'b0;
      r_fd_we      <= 1'b0;
      r_fd_instr   <= '0;
      r_de_valid   <= 1'b0;
      r_de_we      <= 1'b0;
      r_de_op      <= ALU_ADD;
      r_de_use_imm <= 1'b0;
      r_de_rs      <= '0;
      r_de_rt      <= '0;
      r_de_rd      <= '0;
      r_de_rs_val  <= '0;
      r_de_rt_val  <= '0;
      r_de_imm     <= '0;
      r_em_valid   <= 1'b0;
      r_em_we      <= 1'b0;
      r_em_rd      <= '0;
      r_em_data    <= '0;
      r_mw_valid   <= 1'b0;
      r_mw_we      <= 1'b0;
      r_mw_rd      <= '0;
      r_mw_data    <= '0;
      // NOTE: the register file is architecturally cleared by reset, so it is
      // built from flops rather than a RAM macro that cannot be reset.
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
    end else if (!stall) begin
      r_pc         <= r_pc + PC_W'(1);

      r_fd_valid   <= 1'b1;
      r_fd_we      <= writes_reg(imem_data);
      r_fd_instr   <= imem_data;

      r_de_valid   <= r_fd_valid;
      r_de_we      <= r_fd_valid & r_fd_we;
      r_de_op      <= w_dec.op;
      r_de_use_imm <= w_dec.use_imm;
      r_de_rs      <= w_id_rs;
      r_de_rt      <= w_id_rt;
      r_de_rd      <= w_dec.dst;
      r_de_rs_val  <= w_id_rs_val;
      r_de_rt_val  <= w_id_rt_val;
      r_de_imm     <= w_id_imm;

      r_em_valid   <= r_de_valid;
      r_em_we      <= r_de_valid & r_de_we;
      r_em_rd      <= r_de_rd;
      r_em_data    <= w_ex_result;

      r_mw_valid   <= r_em_valid;
      r_mw_we      <= r_em_valid & r_em_we;
      r_mw_rd      <= r_em_rd;
      r_mw_data    <= r_em_data;

      if (w_wb_commit) begin
        r_rf[r_mw_rd] <= r_mw_data;
      end
    end
  end

  assign imem_addr = r_pc;
  assign wb_valid  = w_wb_commit;
  assign wb_rd     = r_mw_rd;
  assign wb_data   = r_mw_data;

endmodule

// File: doc/fwd_pipeline_datapath.md
# fwd_pipeline_datapath

Parametrised five-stage (IF, ID, EX, MM, WB) integer pipeline datapath: the next generation of the team's MIPS-style datapath. It adds a synchronous reset, configurable data and PC widths, an external instruction-memory port, an immediate instruction, full EX/MM/WB operand forwarding, a register-file write bypass, a global stall, and a write-back observation port. Back-to-back dependent instructions execute with no bubbles.

## Interface
- DATA_W, 8: register and ALU width in bits (2..32).
- PC_W, 5: program counter width; instruction address space is 2^PC_W words.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  when high, freezes the whole pipeline for that cycle.
- imem_addr  out  PC_W  instruction fetch address, equal to the PC register.
- imem_data  in  32  instruction word at imem_addr, combinational read within the same cycle.
- wb_valid  out  1  a register write commits this cycle.
- wb_rd  out  5  destination register of the committing write.
- wb_data  out  DATA_W  value written.

## Operation
- Instruction decode:
  - opcode[31:26]=0 is R-type, with rs[25:21], rt[20:16], rd[15:11] and funct[5:0].
  - R-type funct codes: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - opcode 0x08 is addi: rt = rs + sext(imm[15:0]), truncated to the low DATA_W bits.
  - Any other opcode or funct is a NOP and writes nothing.
- Arithmetic:
  - add, sub and addi wrap modulo 2^DATA_W.
  - slt performs a signed DATA_W compare; the result is 1 or 0, zero-extended.
- Register file: 32 x DATA_W.
  - r0 always reads 0.
  - Writes to r0 are discarded, and wb_valid stays 0 for them.
  - Writes occur in WB on the clock edge.
- PC: increments by 1 each non-stalled cycle and wraps from 2^PC_W-1 to 0. There are no branches.
- Each pipeline register (IF/ID, ID/EX, EX/MM, MM/WB) carries a valid bit and a write-enable bit.
- MM is a pass-through stage; there is no data memory.
- Forwarding to the EX operands (rs, rt):
  - Source priority: EX/MM result first, then MM/WB result, then the value read in ID.
  - A source is used only when it is valid, has write-enable set, has a matching register index, and that index is nonzero.
- ID bypass: when WB writes register X in the same cycle that ID reads X (X≠0), the read returns the WB data.
- stall=1 behaviour:
  - PC and all pipeline registers hold their values.
  - The register-file write is suppressed.
  - wb_valid is forced to 0.
  - The held WB instruction commits in the first cycle with stall=0. There is never a duplicate commit.
- wb_valid = MM/WB.valid & MM/WB.we & (rd≠0) & ~stall. wb_rd and wb_data come straight from the MM/WB register.

## Timing
- Reset is taken on a clock edge with rst=1, and overrides stall. After reset:
  - PC=0, so imem_addr=0.
  - All valid bits are 0, so wb_valid=0.
  - wb_rd=0, wb_data=0.
  - All 32 registers are cleared to 0.
- Reset mid-operation discards every in-flight instruction. No commit occurs in the reset cycle.
- Cycle numbering: cycle 0 is the first cycle with rst=0.
- Without stalls, the instruction at address k is in ID in cycle k+1, EX in k+2, MM in k+3 and WB in k+4. It is visible on wb_* in cycle k+4 and readable from the register file from cycle k+5.
- Dependency distance and data source:
  - Distance 1 uses EX/MM forwarding.
  - Distance 2 uses MM/WB forwarding.
  - Distance 3 uses the ID bypass.
  - Distance 4 or more uses a plain register-file read.
- Each stall cycle delays every later event by exactly one cycle.

## Test plan
- Reset and wrap:
  - Stimulus: rst=1 for 3 cycles, then NOPs for 40 cycles.
  - Required response: wb_valid=0 throughout; imem_addr counts 0,1,…,31,0,1,….
- Basic addi and commit latency:
  - Stimulus: addi r1,r0,5 at address 0.
  - Required response: wb_valid=1, wb_rd=1, wb_data=5 exactly in cycle 4.
- Forwarding chain:
  - Stimulus, addresses 0..3: addi r1,r0,100; add r2,r1,r1; sub r3,r2,r1; and r4,r1,r3.
  - Required response: commits r1=100, r2=200, r3=100, r4=100 in cycles 4..7, one commit per cycle.
- Width rules:
  - Stimulus: addi r1,r0,200; add r2,r1,r1; slt r3,r1,r0; addi r4,r0,-1.
  - Required response: r2=144, r3=1, r4=0xFF.
- r0 handling:
  - Stimulus: addi r0,r0,7; add r5,r0,r0.
  - Required response: no commit for r0; r5 commits 0.
- Stall and reset:
  - Stimulus: run the forwarding chain with stall=1 in cycles 5–6, then assert rst in cycle 12 mid-stream.
  - Required response: imem_addr holds during the stall; the commits shift by 2 cycles with identical values and no duplicates; after rst, wb_valid=0 until 4 cycles after release and all registers read 0.
